// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: periodic MOVE_TICK with a score-dependent period, and
// arbitration of the direction buttons. Optional pause feature: SNAKE_PAUSE_EN.
module snake_move_scheduler #(
    parameter int TICK_DIV   = 10_000_000,
    parameter int SPEED_STEP = 500_000,
    parameter int MIN_DIV    = 2_000_000,
    parameter int CNT_W      = 24,
    parameter int SCORE_W    = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         MSM_STATE,
    input  logic               BTNU,
    input  logic               BTNL,
    input  logic               BTNR,
    input  logic               BTND,
    input  logic [SCORE_W-1:0] SCORE_IN,
`ifdef SNAKE_PAUSE_EN
    input  logic               BTNC,
    output logic               PAUSED,
`endif
    output logic [1:0]         DIRECTION,
    output logic               MOVE_TICK
);
    localparam int PW = CNT_W + SCORE_W;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

`ifdef SNAKE_PAUSE_EN
    localparam int NB = 5;
    logic [NB-1:0] raw;
    assign raw = {BTNC, BTND, BTNR, BTNL, BTNU};
`else
    localparam int NB = 4;
    logic [NB-1:0] raw;
    assign raw = {BTND, BTNR, BTNL, BTNU};
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
    state_t state_reg, state_next;

    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    per_reg;
    logic [1:0]       pending_reg;
    logic [PW-1:0]    step_prod;
    logic [PW-1:0]    per_now;
    logic [PW-1:0]    per_cur;
    logic             tick_hit;
    logic             win_valid;
    logic [1:0]       win_dir;
    logic             accept;
    logic             pause_active;

    // Per button: two synchroniser flops followed by a one-flop edge detector.
    // Bit index matches the direction code (0 up, 1 left, 2 right, 3 down).
    for (genvar gi = 0; gi < NB; gi++) begin : g_sync
        logic [2:0] sh_reg;
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) sh_reg <= '0;
            else       sh_reg <= {sh_reg[1:0], raw[gi]};
        end
        assign press[gi] = sh_reg[1] & ~sh_reg[2];
    end

    // Period computed wide so the subtraction can never wrap.
    always_comb begin
        step_prod = PW'(SCORE_IN) * PW'(SPEED_STEP);
        if (step_prod >= PW'(TICK_DIV - MIN_DIV)) per_now = PW'(MIN_DIV);
        else                                      per_now = PW'(TICK_DIV) - step_prod;
        per_cur  = (cnt_reg == '0) ? per_now : per_reg;
        tick_hit = ({{SCORE_W{1'b0}}, cnt_reg} == per_cur - PW'(1));
    end

    always_comb begin
        win_valid = 1'b1;
        win_dir   = 2'b00;
        if      (press[0]) win_dir = 2'b00;
        else if (press[1]) win_dir = 2'b01;
        else if (press[2]) win_dir = 2'b10;
        else if (press[3]) win_dir = 2'b11;
        else               win_valid = 1'b0;
        // Opposite directions differ in both bits.
        accept = win_valid && (win_dir != ~DIRECTION);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (MSM_STATE == 2'b01) state_next = S_RUN;
            S_RUN: begin
                if (MSM_STATE == 2'b00)   state_next = S_IDLE;
                else if (MSM_STATE[1])    state_next = S_HALT;
            end
            S_HALT: begin
                if (MSM_STATE == 2'b00)      state_next = S_IDLE;
                else if (MSM_STATE == 2'b01) state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef SNAKE_PAUSE_EN
    logic paused_reg;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                     paused_reg <= 1'b0;
        else if (state_next != S_RUN)                  paused_reg <= 1'b0;
        else if (state_reg == S_RUN && press[NB-1])    paused_reg <= ~paused_reg;
    end
    assign PAUSED       = paused_reg;
    assign pause_active = paused_reg;
`else
    assign pause_active = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_reg     <= '0;
            per_reg     <= '0;
            pending_reg <= DIR_RIGHT;
            DIRECTION   <= DIR_RIGHT;
            MOVE_TICK   <= 1'b0;
        end else begin
            MOVE_TICK <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg     <= '0;
                    pending_reg <= DIR_RIGHT;
                    DIRECTION   <= DIR_RIGHT;
                end
                S_RUN: begin
                    if (!pause_active) begin
                        if (cnt_reg == '0) per_reg <= per_now;
                        if (tick_hit) begin
                            cnt_reg   <= '0;
                            MOVE_TICK <= 1'b1;
                            DIRECTION <= pending_reg;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                        // A press on the tick edge lands in pending, not DIRECTION.
                        if (accept) pending_reg <= win_dir;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed steps plus random stimulus checked
// against a behavioural model of the tick / direction rules.
module tb_snake_move_scheduler;
    localparam int TD = 20, SS = 4, MD = 8, CW = 8, SW = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] msm = 2'b00;
    logic bu = 0, bl = 0, br = 0, bd = 0;
    logic [SW-1:0] score = '0;
    logic [1:0] dir;
    logic tick;
`ifdef SNAKE_PAUSE_EN
    logic bc = 0;
    logic paused;
`endif

    always #5 clk = ~clk;

    snake_move_scheduler #(.TICK_DIV(TD), .SPEED_STEP(SS), .MIN_DIV(MD),
                           .CNT_W(CW), .SCORE_W(SW)) dut (
        .CLK(clk), .RESET(rst), .MSM_STATE(msm),
        .BTNU(bu), .BTNL(bl), .BTNR(br), .BTND(bd), .SCORE_IN(score),
`ifdef SNAKE_PAUSE_EN
        .BTNC(bc), .PAUSED(paused),
`endif
        .DIRECTION(dir), .MOVE_TICK(tick));

    int total = 0, bad = 0;
    // model: mode 0 idle, 1 run, 2 halt
    int m_mode, m_cnt, m_lat, m_pend, m_dir, m_tick, m_paused;
    int h1[5], h2[5], h3[5];

    function automatic int period(int s);
        int p;
        p = TD - s * SS;
        return (p < MD) ? MD : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_lat = 0; m_pend = 2; m_dir = 2; m_tick = 0; m_paused = 0;
        for (int i = 0; i < 5; i++) begin h1[i] = 0; h2[i] = 0; h3[i] = 0; end
    endtask

    task automatic model_edge();
        int raw[5];
        int pr[5];
        int nxt, p, win, new_dir;
        raw[0] = int'(bu); raw[1] = int'(bl); raw[2] = int'(br); raw[3] = int'(bd); raw[4] = 0;
`ifdef SNAKE_PAUSE_EN
        raw[4] = int'(bc);
`endif
        // press acted on at the third edge after the raw level is first sampled
        for (int i = 0; i < 5; i++) begin
            pr[i] = (h2[i] != 0 && h3[i] == 0) ? 1 : 0;
            h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = raw[i];
        end
        if (msm == 2'b00)      nxt = 0;
        else if (msm == 2'b01) nxt = 1;
        else                   nxt = (m_mode == 0) ? 0 : 2;
        new_dir = m_dir;
        m_tick = 0;
        if (m_mode == 0) begin
            m_cnt = 0; m_pend = 2; new_dir = 2;
        end else if (m_mode == 1 && m_paused == 0) begin
            p = (m_cnt == 0) ? period(int'(score)) : m_lat;
            if (m_cnt == 0) m_lat = p;
            if (m_cnt == p - 1) begin m_tick = 1; m_cnt = 0; new_dir = m_pend; end
            else m_cnt++;
            win = -1;
            for (int i = 3; i >= 0; i--) if (pr[i] != 0) win = i;
            if (win >= 0 && win != 3 - m_dir) m_pend = win;
        end
        if (nxt != 1)                      m_paused = 0;
        else if (m_mode == 1 && pr[4] != 0) m_paused = 1 - m_paused;
        m_dir = new_dir;
        m_mode = nxt;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tick", tick, m_tick);
        chk("dir", dir, m_dir);
`ifdef SNAKE_PAUSE_EN
        chk("paused", paused, m_paused);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin cyc(); n++; end while (tick !== 1'b1 && n < 100);
        chk("wait_tick", tick, 1);
    endtask

    task automatic wait_cnt(input int c);
        int n;
        n = 0;
        while (m_cnt != c && n < 100) begin cyc(); n++; end
        chk("wait_cnt", m_cnt, c);
    endtask

    initial begin
        int t, gap, nt;
        int tt[3];
        model_reset();
        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_dir", dir, 2);
        chk("rst_tick", tick, 0);
        rst = 1'b0;

        // 1: ticks every 20 cycles after entering run (one edge to enter run)
        msm = 2'b01;
        nt = 0;
        for (t = 1; t <= 62; t++) begin
            cyc();
            if (tick === 1'b1 && nt < 3) begin tt[nt] = t; nt++; end
        end
        chk("t1_tick0", tt[0], TD + 1);
        chk("t1_tick1", tt[1], 2 * TD + 1);
        chk("t1_tick2", tt[2], 3 * TD + 1);
        chk("t1_dir", dir, 2);

        // 2: score-dependent period, mid-interval change waits for next interval
        wait_tick(gap);
        score = 4'd2;
        wait_tick(gap); chk("t2_p12", gap, 12);
        score = 4'd5;
        wait_tick(gap); chk("t2_p8", gap, 8);
        run(3);
        score = 4'd0;
        wait_tick(gap); chk("t2_old", gap, 5);
        wait_tick(gap); chk("t2_new", gap, 20);

        // 3: opposite press ignored, valid press commits only at tick
        bl = 1; run(4); bl = 0;
        wait_tick(gap); chk("t3_left_ign", dir, 2);
        bu = 1; run(4); bu = 0;
        chk("t3_hold", dir, 2);
        wait_tick(gap); chk("t3_commit", dir, 0);

        // 4: simultaneous U+D from right -> U; later D is opposite of U
        msm = 2'b00; run(2); chk("t4_idle_dir", dir, 2);
        msm = 2'b01; run(2);
        bu = 1; bd = 1; run(4); bu = 0; bd = 0;
        wait_tick(gap); chk("t4_up", dir, 0);
        bd = 1; run(4); bd = 0;
        wait_tick(gap); chk("t4_down_rej", dir, 0);

        // 5: halt freezes, idle clears, rerun restarts full period
        wait_cnt(7);
        msm = 2'b10;
        nt = 0;
        for (int i = 0; i < 30; i++) begin cyc(); if (tick === 1'b1) nt++; end
        chk("t5_halt_ticks", nt, 0);
        msm = 2'b00; run(2); chk("t5_idle_dir", dir, 2);
        msm = 2'b01;
        wait_tick(gap); chk("t5_first", gap, TD + 1);

        // 6: async reset mid-interval with DIRECTION=up
        bu = 1; run(4); bu = 0;
        wait_tick(gap); chk("t6_up", dir, 0);
        wait_cnt(13);
        #2 rst = 1'b1;
        #1 chk("t6_async_dir", dir, 2);
        chk("t6_async_tick", tick, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_tick(gap); chk("t6_restart", gap, TD + 1);

`ifdef SNAKE_PAUSE_EN
        bc = 1; run(4); bc = 0;
        chk("pause_on", paused, 1);
        nt = 0;
        for (int i = 0; i < 30; i++) begin cyc(); if (tick === 1'b1) nt++; end
        chk("pause_ticks", nt, 0);
        bc = 1; run(4); bc = 0;
        chk("pause_off", paused, 0);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) msm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) score = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) bu = ~bu;
            if ($urandom_range(0, 5) == 0) bl = ~bl;
            if ($urandom_range(0, 5) == 0) br = ~br;
            if ($urandom_range(0, 5) == 0) bd = ~bd;
`ifdef SNAKE_PAUSE_EN
            if ($urandom_range(0, 40) == 0) bc = ~bc;
`endif
            if ($urandom_range(0, 29) == 0 && msm == 2'b00) msm = 2'b01;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
